// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing one synchronous RAM; a registered request is
// issued for one cycle, and its read data returns with a one-cycle ack.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter bit RR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ACK = 2'd3;
  logic [1:0] state;
  logic       last_grant, gnt, sel;
  always_comb sel = (m0_req && m1_req) ? (RR ? !last_grant : 1'b0) : !m0_req;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (m0_req || m1_req) begin
          gnt        <= sel;
          last_grant <= sel;
          mem_addr   <= sel ? m1_addr : m0_addr;
          mem_we     <= sel ? m1_we : m0_we;
          mem_wdata  <= sel ? m1_wdata : m0_wdata;
          state      <= ISSUE;
        end
        ISSUE: begin
          mem_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (gnt) begin
            m1_rdata <= mem_rdata;
            m1_ack   <= 1'b1;
          end else begin
            m0_rdata <= mem_rdata;
            m0_ack   <= 1'b1;
          end
          state <= ACK;
        end
        default: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random transactions against a transaction-level model
// of the arbiter plus a write-first RAM; a second instance covers fixed priority.
module tb_mem_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [7:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic       m0_ack, m1_ack, mem_we, busy;
  logic [7:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 0;
  logic       f0_req = 0, f1_req = 0, f_ack0, f_ack1, f_we, f_busy;
  logic       f_zero_we = 0;
  logic [7:0] f_zero = 0, f_rd0, f_rd1, f_addr, f_wdata;
  logic [7:0] f_ram_rd = 8'h3C;
  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rd [2];
  int         checks = 0, errors = 0, we_cycles = 0, exp_writes = 0, last_g = 1;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(8), .DW(8), .RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_arbiter #(.AW(8), .DW(8), .RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(f0_req), .m0_we(f_zero_we), .m0_addr(f_zero), .m0_wdata(f_zero),
    .m0_ack(f_ack0), .m0_rdata(f_rd0),
    .m1_req(f1_req), .m1_we(f_zero_we), .m1_addr(f_zero), .m1_wdata(f_zero),
    .m1_ack(f_ack1), .m1_rdata(f_rd1),
    .mem_addr(f_addr), .mem_we(f_we), .mem_wdata(f_wdata), .mem_rdata(f_ram_rd),
    .busy(f_busy)
  );

  // write-first RAM: a write cycle returns the written value
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    if (mem_we) we_cycles <= we_cycles + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  // one arbitration slot starting in IDLE; drop releases the granted port at its ack
  task automatic txn(input bit drop);
    int g;
    logic       we;
    logic [7:0] a, d, e;
    if (!m0_req && !m1_req) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_we", mem_we, 0);
      return;
    end
    g  = (m0_req && m1_req) ? 1 - last_g : (m1_req ? 1 : 0);
    we = g ? m1_we : m0_we;
    a  = g ? m1_addr : m0_addr;
    d  = g ? m1_wdata : m0_wdata;
    if (we) begin
      ref_mem[a] = d;
      exp_writes++;
    end
    e = ref_mem[a];
    last_g = g;
    tick();
    chk("issue_busy", busy, 1);
    chk("issue_we", mem_we, we);
    chk("issue_addr", mem_addr, a);
    if (we) chk("issue_wdata", mem_wdata, d);
    chk("issue_acks", {m1_ack, m0_ack}, 0);
    tick();
    chk("wait_we", mem_we, 0);
    chk("wait_acks", {m1_ack, m0_ack}, 0);
    tick();
    exp_rd[g] = e;
    chk("ack_port", {m1_ack, m0_ack}, g ? 2'b10 : 2'b01);
    chk("ack_rdata", g ? m1_rdata : m0_rdata, e);
    chk("other_rdata", g ? m0_rdata : m1_rdata, exp_rd[1-g]);
    chk("ack_we", mem_we, 0);
    if (drop) begin
      if (g) m1_req = 0; else m0_req = 0;
    end
    tick();
    chk("post_acks", {m1_ack, m0_ack}, 0);
    chk("post_busy", busy, 0);
  endtask

  task automatic wait_f(output int p);
    p = -1;
    for (int i = 0; i < 10 && p < 0; i++) begin
      tick();
      if (f_ack0) p = 0;
      else if (f_ack1) p = 1;
    end
  endtask

  initial begin
    int p;
    for (int i = 0; i < 256; i++) begin
      ram[i] <= 8'h00;
      ref_mem[i] = 8'h00;
    end
    ram[8'hFE] <= 8'h01;
    ref_mem[8'hFE] = 8'h01;
    exp_rd[0] = 0;
    exp_rd[1] = 0;
    #2;
    chk("rst_outs", {mem_we, busy, m0_ack, m1_ack, mem_addr, mem_wdata}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    tick();
    rst = 0;
    // fixed priority: port 0 keeps winning while it requests
    f0_req = 1; f1_req = 1;
    for (int k = 0; k < 3; k++) begin
      wait_f(p);
      chk("fp_grant0", p, 0);
    end
    f0_req = 0;
    wait_f(p);
    chk("fp_grant1", p, 1);
    chk("fp_rdata1", f_rd1, 8'h3C);
    f1_req = 0;
    tick();
    tick();
    // round-robin with both requesting continuously
    set_req(0, 0, 8'h01, 0);
    set_req(1, 0, 8'h02, 0);
    for (int k = 0; k < 4; k++) txn(0);
    m0_req = 0; m1_req = 0;
    // single read, then write at top address and read it back
    set_req(0, 0, 8'hFE, 0);
    txn(1);
    set_req(1, 1, 8'hFF, 8'hA5);
    txn(1);
    set_req(0, 0, 8'hFF, 0);
    txn(1);
    // held request: every access still takes exactly four cycles
    set_req(0, 0, 8'hFE, 0);
    for (int k = 0; k < 3; k++) txn(0);
    m0_req = 0;
    txn(1);
    for (int k = 0; k < 40; k++) begin
      for (int q = 0; q < 2; q++)
        if (!(q ? m1_req : m0_req) && $urandom_range(0, 1))
          set_req(q, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom_range(0, 7)),
                  8'($urandom));
      txn(1);
    end
    m0_req = 0; m1_req = 0;
    tick();
    chk("we_cycles", we_cycles, exp_writes);
    // reset during the issue cycle of a write
    set_req(0, 1, 8'h10, 8'h55);
    tick();
    chk("pre_rst_we", mem_we, 1);
    #2 rst = 1;
    #1;
    chk("rst_mid", {mem_we, busy, m0_ack, m1_ack}, 0);
    m0_req = 0;
    tick();
    rst = 0;
    last_g = 1;
    exp_rd[0] = 0;
    exp_rd[1] = 0;
    chk("rst_ram", ram[8'h10], ref_mem[8'h10]);
    chk("rst_we_cycles", we_cycles, exp_writes);
    set_req(0, 0, 8'h10, 0);
    txn(1);
    set_req(1, 0, 8'hFF, 0);
    txn(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
